// File: rtl/alu_writeback_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions, flag struct.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package alu_writeback_pkg;

    localparam int DATA_W   = 32;
    localparam int OPCODE_W = 5;
    localparam int FLAGS_W  = 4;

    typedef logic [OPCODE_W-1:0] opcode_t;

    // ALU opcode encodings shared with the execute stage.
    localparam opcode_t OP_NOP = 5'd0;
    localparam opcode_t OP_ADD = 5'd1;
    localparam opcode_t OP_SUB = 5'd2;
    localparam opcode_t OP_AND = 5'd3;
    localparam opcode_t OP_OR  = 5'd4;
    localparam opcode_t OP_XOR = 5'd5;
    localparam opcode_t OP_NOT = 5'd6;
    localparam opcode_t OP_SHL = 5'd7;

    // Bit positions inside the 4-bit flag word {C,S,O,Z}.
    localparam int FLAG_C = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 0;

    // Packed so that c lands on FLAG_C and z on FLAG_Z.
    typedef struct packed {
        logic c;
        logic s;
        logic o;
        logic z;
    } flags_t;

    // Everything except OP_NOP commits architectural state on drain.
    function automatic logic op_commits(opcode_t op);
        return op != OP_NOP;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO for writeback entries; exposes a low-bit tag of every slot for hazard snooping.
// Latency: an entry pushed at edge N is at the head after edge N (poppable at edge N+1).
// Backpressure: push ignored when full, pop ignored when empty; full is a decode of the registered count.
//
// Ports: clk/reset (async, active-high); push/push_dat write side; pop/head_dat read side;
//        count/full/empty occupancy; occupied[i] marks live slots; snoop_tag[i] = low TAG_W bits of slot i.
module wb_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    parameter  int TAG_W = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_dat,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_dat,
    output logic [CNT_W-1:0]               count,
    output logic                           full,
    output logic                           empty,
    output logic [DEPTH-1:0]               occupied,
    output logic [DEPTH-1:0][TAG_W-1:0]    snoop_tag
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push != do_pop) begin
                count <= do_push ? count + CNT_W'(1) : count - CNT_W'(1);
            end
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        occupied  = '0;
        snoop_tag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i]  = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
            snoop_tag[i] = mem[i][TAG_W-1:0];
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: buffers ALU results, drains the oldest into the register file and flag register.
// Latency: a push into an empty buffer with hold=0 is written at the next edge; reads see it one cycle later.
// Backpressure: in_ready drops when the buffer is full (from registered count only); hold stalls draining.
//
// Ports: clk, reset (async, active-high); in_valid/in_ready with resultado, C/S/O/Z, opcode, dest;
//        hold stalls the register-file write port; ra/rb -> rd_a/rd_b combinational reads;
//        pend_a/pend_b flag undrained writes to ra/rb; flags = {C,S,O,Z}; count = buffer occupancy.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int NREGS = 8,
    localparam int IDX_W = $clog2(NREGS),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    resultado,
    input  logic                 C,
    input  logic                 S,
    input  logic                 O,
    input  logic                 Z,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [IDX_W-1:0]     dest,
    input  logic                 hold,
    input  logic [IDX_W-1:0]     ra,
    input  logic [IDX_W-1:0]     rb,
    output logic [DATA_W-1:0]    rd_a,
    output logic [DATA_W-1:0]    rd_b,
    output logic                 pend_a,
    output logic                 pend_b,
    output logic [FLAGS_W-1:0]   flags,
    output logic [CNT_W-1:0]     count
);

    // opcode/dest sit in the low bits so the FIFO can snoop them cheaply.
    typedef struct packed {
        opcode_t          opcode;
        logic [IDX_W-1:0] dest;
    } wb_tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        flags_t            flg;
        wb_tag_t           tag;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);
    localparam int TAG_W   = $bits(wb_tag_t);

    wb_entry_t                 push_entry;
    wb_entry_t                 head_entry;
    wb_tag_t [DEPTH-1:0]       snoop_tag;
    logic    [DEPTH-1:0]       occupied;
    logic                      full;
    logic                      empty;
    logic                      drain;
    logic    [DATA_W-1:0]      regs [NREGS];

    assign push_entry = {resultado, C, S, O, Z, opcode, dest};
    assign in_ready   = !full;
    assign drain      = !hold && !empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .TAG_W (TAG_W)
    ) u_wb_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_dat  (push_entry),
        .pop       (drain),
        .head_dat  (head_entry),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .occupied  (occupied),
        .snoop_tag (snoop_tag)
    );

    // Register 0 is never written so it stays at its reset value of zero.
    // NOP entries leave both the register file and the flags untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            flags <= '0;
        end else if (drain && op_commits(head_entry.tag.opcode)) begin
            flags <= head_entry.flg;
            if (head_entry.tag.dest != '0) begin
                regs[head_entry.tag.dest] <= head_entry.result;
            end
        end
    end

    // No bypass from the buffer: consumers use pend_* to stall instead.
    assign rd_a = (ra == '0) ? '0 : regs[ra];
    assign rd_b = (rb == '0) ? '0 : regs[rb];

    always_comb begin
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && op_commits(snoop_tag[i].opcode) && snoop_tag[i].dest != '0) begin
                if (snoop_tag[i].dest == ra) pend_a = 1'b1;
                if (snoop_tag[i].dest == rb) pend_b = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    localparam int DEPTH = 2;
    localparam int NREGS = 8;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] res;
    logic [3:0]  flg;
    logic [4:0]  op;
    logic [2:0]  dst;
    logic        hold;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        pend_a;
    logic        pend_b;
    logic [3:0]  flags;
    logic [1:0]  count;

    int checks   = 0;
    int failures = 0;

    alu_writeback #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .resultado (res),
        .C         (flg[3]),
        .S         (flg[2]),
        .O         (flg[1]),
        .Z         (flg[0]),
        .opcode    (op),
        .dest      (dst),
        .hold      (hold),
        .ra        (ra),
        .rb        (rb),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .pend_a    (pend_a),
        .pend_b    (pend_b),
        .flags     (flags),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: an ordered list of buffered writes plus architectural state.
    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [4:0]  op;
        logic [2:0]  dst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_regs [NREGS];
    logic [3:0]  m_flags;

    task automatic model_reset();
        mq.delete();
        m_flags = 4'b0000;
        for (int i = 0; i < NREGS; i++) m_regs[i] = 32'h0;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [31:0] ea;
        logic [31:0] eb;
        logic        pa;
        logic        pb;
        #1;
        ea = (ra == 3'd0) ? 32'h0 : m_regs[ra];
        eb = (rb == 3'd0) ? 32'h0 : m_regs[rb];
        pa = 1'b0;
        pb = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].op != OP_NOP && mq[i].dst != 3'd0) begin
                if (mq[i].dst == ra) pa = 1'b1;
                if (mq[i].dst == rb) pb = 1'b1;
            end
        end
        chk({tag, ".count"},    {30'h0, count},    32'(mq.size()));
        chk({tag, ".in_ready"}, {31'h0, in_ready}, {31'h0, mq.size() < DEPTH});
        chk({tag, ".flags"},    {28'h0, flags},    {28'h0, m_flags});
        chk({tag, ".rd_a"},     rd_a,              ea);
        chk({tag, ".rd_b"},     rd_b,              eb);
        chk({tag, ".pend_a"},   {31'h0, pend_a},   {31'h0, pa});
        chk({tag, ".pend_b"},   {31'h0, pend_b},   {31'h0, pb});
    endtask

    task automatic set_in(logic v, logic [31:0] r, logic [3:0] f, logic [4:0] o, logic [2:0] d, logic h);
        in_valid = v;
        res      = r;
        flg      = f;
        op       = o;
        dst      = d;
        hold     = h;
    endtask

    // One clock: decide push/pop from the model, advance, then compare everything.
    task automatic tick(string tag);
        logic do_push;
        logic do_pop;
        ent_t e;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = !hold && (mq.size() > 0);
        @(posedge clk);
        if (do_pop) begin
            e = mq.pop_front();
            if (e.op != OP_NOP) begin
                m_flags = e.flg;
                if (e.dst != 3'd0) m_regs[e.dst] = e.res;
            end
        end
        if (do_push) mq.push_back('{res: res, flg: flg, op: op, dst: dst});
        #1;
        check_all(tag);
    endtask

    logic [3:0]  prev_flags;
    logic [31:0] prev_r4;
    logic [4:0]  rop;
    int          hold_pct;

    initial begin
        reset = 1'b1;
        ra    = 3'd0;
        rb    = 3'd0;
        set_in(1'b0, 32'h0, 4'h0, OP_NOP, 3'd0, 1'b0);
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b0;

        // Single ADD to r3 with carry set, drained the following edge.
        ra = 3'd3;
        set_in(1'b1, 32'h0000_0001, 4'b1000, OP_ADD, 3'd3, 1'b0);
        tick("t34_push");
        chk("t34_cnt_after_push", {30'h0, count}, 32'd1);
        chk("t34_pend", {31'h0, pend_a}, 32'd1);
        set_in(1'b0, 32'h0, 4'h0, OP_NOP, 3'd0, 1'b0);
        tick("t34_drain");
        chk("t34_cnt", {30'h0, count}, 32'd0);
        chk("t34_rd_a", rd_a, 32'h0000_0001);
        chk("t34_flags", {28'h0, flags}, 32'h8);

        // Two entries under hold, then in-order drain.
        set_in(1'b1, 32'hACED_CAFE, 4'b0100, OP_ADD, 3'd2, 1'b1);
        tick("t35_p1");
        set_in(1'b1, 32'h5312_3501, 4'b0001, OP_SUB, 3'd5, 1'b1);
        tick("t35_p2");
        set_in(1'b0, 32'h0, 4'h0, OP_NOP, 3'd0, 1'b1);
        ra = 3'd2;
        rb = 3'd5;
        check_all("t35_full");
        chk("t35_count", {30'h0, count}, 32'd2);
        chk("t35_in_ready", {31'h0, in_ready}, 32'd0);
        chk("t35_pend_a_r2", {31'h0, pend_a}, 32'd1);
        ra = 3'd5;
        #1;
        chk("t35_pend_a_r5", {31'h0, pend_a}, 32'd1);
        ra = 3'd2;
        hold = 1'b0;
        tick("t35_d1");
        chk("t35_rd_a_first", rd_a, 32'hACED_CAFE);
        chk("t35_rd_b_not_yet", rd_b, 32'h0);
        tick("t35_d2");
        chk("t35_rd_b_second", rd_b, 32'h5312_3501);
        chk("t35_flags", {28'h0, flags}, 32'h1);

        // Full buffer with drain and a new push in the same cycle.
        set_in(1'b1, 32'h0000_0011, 4'b0010, OP_AND, 3'd6, 1'b1);
        tick("t36_f1");
        set_in(1'b1, 32'h0000_0022, 4'b0011, OP_OR, 3'd7, 1'b1);
        tick("t36_f2");
        set_in(1'b1, 32'h0000_0033, 4'b0000, OP_XOR, 3'd1, 1'b0);
        ra = 3'd6;
        rb = 3'd7;
        check_all("t36_pre");
        chk("t36_in_ready_full", {31'h0, in_ready}, 32'd0);
        tick("t36_e1");
        chk("t36_count_e1", {30'h0, count}, 32'd1);
        chk("t36_rd_a_e1", rd_a, 32'h0000_0011);
        tick("t36_e2");
        chk("t36_count_e2", {30'h0, count}, 32'd1);
        chk("t36_rd_b_e2", rd_b, 32'h0000_0022);
        set_in(1'b0, 32'h0, 4'h0, OP_NOP, 3'd0, 1'b0);
        ra = 3'd1;
        tick("t36_e3");
        chk("t36_rd_a_e3", rd_a, 32'h0000_0033);

        // NOP must not disturb register 4 or the flags.
        ra = 3'd4;
        rb = 3'd4;
        prev_flags = m_flags;
        prev_r4    = m_regs[4];
        set_in(1'b1, 32'hFFFF_FFFF, 4'b1111, OP_NOP, 3'd4, 1'b0);
        tick("t37_push");
        chk("t37_pend_a", {31'h0, pend_a}, 32'd0);
        set_in(1'b0, 32'h0, 4'h0, OP_NOP, 3'd0, 1'b0);
        tick("t37_drain");
        chk("t37_rd_a", rd_a, prev_r4);
        chk("t37_flags", {28'h0, flags}, {28'h0, prev_flags});

        // Write to r0 is dropped but its flags land.
        ra = 3'd0;
        set_in(1'b1, 32'h8000_0000, 4'b1011, OP_ADD, 3'd0, 1'b0);
        tick("t38_push");
        chk("t38_pend_a", {31'h0, pend_a}, 32'd0);
        set_in(1'b0, 32'h0, 4'h0, OP_NOP, 3'd0, 1'b0);
        tick("t38_drain");
        chk("t38_rd0", rd_a, 32'h0);
        chk("t38_flags", {28'h0, flags}, 32'hB);

        // Random traffic; hold pressure alternates to exercise both full and empty.
        for (int n = 0; n < 400; n++) begin
            hold_pct = ((n / 50) % 2 == 1) ? 70 : 20;
            rop = ($urandom_range(0, 3) == 0) ? OP_NOP : 5'($urandom_range(1, 7));
            set_in(1'($urandom_range(0, 1)), $urandom, 4'($urandom), rop, 3'($urandom),
                   1'($urandom_range(0, 99) < hold_pct));
            ra = 3'($urandom);
            rb = 3'($urandom);
            tick("rand");
        end

        // Asynchronous reset with writes still buffered.
        set_in(1'b1, 32'hDEAD_BEEF, 4'b1111, OP_ADD, 3'd3, 1'b1);
        tick("t39_p1");
        set_in(1'b1, 32'hCAFE_F00D, 4'b0101, OP_SUB, 3'd6, 1'b1);
        tick("t39_p2");
        set_in(1'b0, 32'h0, 4'h0, OP_NOP, 3'd0, 1'b1);
        ra = 3'd3;
        rb = 3'd6;
        #3;
        reset = 1'b1;
        model_reset();
        check_all("t39_rst");
        chk("t39_count", {30'h0, count}, 32'd0);
        chk("t39_flags", {28'h0, flags}, 32'h0);
        chk("t39_rd_a", rd_a, 32'h0);
        chk("t39_rd_b", rd_b, 32'h0);
        chk("t39_in_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        hold  = 1'b0;
        tick("t39_idle1");
        tick("t39_idle2");
        for (int r = 0; r < NREGS; r++) begin
            ra = 3'(r);
            rb = 3'(NREGS - 1 - r);
            check_all("t39_sweep");
            chk("t39_sweep_zero", rd_a, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered writeback entries (power of two, 2 or 4).
REQ-002 Parameter NREGS, default 8, register-file entries; index width = clog2(NREGS).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  ALU result, flags and tag presented this cycle.
REQ-006 in_ready  output  1  buffer can accept an entry this cycle.
REQ-007 resultado  input  32  ALU result.
REQ-008 C, S, O, Z  input  1 each  ALU carry, sign, overflow, zero flags.
REQ-009 opcode  input  5  opcode that produced resultado.
REQ-010 dest  input  clog2(NREGS)  destination register index.
REQ-011 hold  input  1  register-file write port blocked; no drain this cycle.
REQ-012 ra, rb  input  clog2(NREGS) each  operand read addresses for the upstream stage.
REQ-013 rd_a, rd_b  output  32 each  register contents at ra, rb.
REQ-014 pend_a, pend_b  output  1 each  a buffered, undrained entry targets ra / rb.
REQ-015 flags  output  4  architectural flag register {C,S,O,Z}.
REQ-016 count  output  clog2(DEPTH)+1  occupied buffer entries.

Function
REQ-017 Accept (push) occurs when in_valid && in_ready at a rising edge; entry = {resultado, C,S,O,Z, opcode, dest}.
REQ-018 in_ready = (count < DEPTH), derived from registered count only; no combinational path from hold or in_valid.
REQ-019 Drain (pop) occurs at a rising edge when count > 0 && !hold; exactly the oldest entry, at most one per cycle.
REQ-020 Push and pop in the same cycle both take effect; count unchanged; order preserved.
REQ-021 Pointers wrap modulo DEPTH; count saturates neither direction because push blocked when full, pop blocked when empty.
REQ-022 On drain, if entry opcode != OP_NOP and dest != 0, regfile[dest] <= result.
REQ-023 On drain, if entry opcode != OP_NOP, flags <= entry {C,S,O,Z}; OP_NOP entries change no state besides the buffer.
REQ-024 Register 0 always reads 0; writes to it are discarded (flags still update).
REQ-025 rd_a/rd_b are combinational reads of the register file; a drained value is visible the cycle after its drain edge (no bypass).
REQ-026 pend_a = 1 iff some occupied entry has opcode != OP_NOP, dest == ra, dest != 0; pend_b likewise for rb.
REQ-027 Latency: entry pushed into empty buffer with hold=0 is written at the next edge (1 cycle buffered residence).
REQ-028 X on resultado/C/S/O/Z is stored as-is; no checking.

Reset
REQ-029 While reset=1: count=0, pointers=0, all registers=0, flags=4'b0000, in_ready=1, pend_a=pend_b=0.
REQ-030 Reset asserted mid-operation discards all buffered entries immediately; no pending write completes.
REQ-031 First push accepted at the first rising edge after reset deasserts.

Structure
REQ-032 Opcode encodings (OP_NOP, OP_ADD, OP_NOT, ...) and flag bit positions live in the shared ALU defines include; this block does not redefine them.
REQ-033 The buffer is one sub-module, wb_fifo (push/pop/count, parameter DEPTH, payload width parameter); register file and flag register stay in alu_writeback.

Verification
REQ-034 Push OP_ADD, resultado=32'h0000_0001, flags {1,0,0,0}, dest=3, hold=0 -> edge+1: count=0, rd_a(ra=3)=32'h0000_0001, flags=4'b1000.
REQ-035 hold=1, push two entries (dest=2, 32'hACED_CAFE; dest=5, 32'h5312_3501) -> count=2, in_ready=0, pend_a=1 for ra=2 and ra=5; release hold -> written in order on two consecutive edges.
REQ-036 Full buffer, hold=0, in_valid=1 same cycle -> pop occurs, push refused (in_ready=0 sampled), count=1 after edge; next edge push accepted.
REQ-037 Push OP_NOP with dest=4, resultado=32'hFFFF_FFFF, flags {1,1,1,1} -> regfile[4] and flags unchanged, pend never asserted.
REQ-038 Push OP_ADD dest=0, resultado=32'h8000_0000, flags {1,0,1,1} -> rd(0)=0, flags=4'b1011.
REQ-039 Two entries buffered under hold, assert reset asynchronously mid-cycle -> count=0, flags=0, all rd=0 immediately, no write after release.
